dmem_access_unit: RTL and testbench

MEM-stage data-memory access controller for the pipelined RV32I core; the write-side counterpart of writeback load extraction. Takes the effective address and store data from the EX/MEM register, builds the word-aligned address, byte-enable mask and lane-replicated store data, and runs the request/response handshake with the data cache. Holds the pipeline with `mem_stall` until the access completes, then presents the raw read word and address offset for writeback extraction.

---
 rtl/dmem_access_unit.sv | 175 +++++++++++++++++
 tb/tb_dmem_access_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access controller.
// Converts the EX/MEM effective address and store data into a word-aligned
// cache request with byte enables and lane-replicated write data. It also runs
// the request/response handshake with the data cache, holding the pipeline
// until the cache answers. The raw read word and the address offset are kept
// for load extraction in writeback.
module dmem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_read_req,
    input  logic        mem_write_req,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_out,
    input  logic [31:0] data_rdata,
    input  logic        data_resp,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_addr,
    output logic [3:0]  data_mbe,
    output logic [31:0] data_wdata,
    output logic [31:0] load_data,
    output logic [1:0]  addr_low,
    output logic        mem_stall,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        data_read_q, data_read_d;
    logic        data_write_q, data_write_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [3:0]  data_mbe_q, data_mbe_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic [1:0]  addr_low_q, addr_low_d;

    logic        req_s;
    logic [1:0]  off_s;
    logic [3:0]  enc_mbe_s;
    logic [31:0] enc_wdata_s;
    logic        store_mis_s;
    logic        stall_s;
    logic        mis_s;

    assign req_s = mem_valid & (mem_read_req | mem_write_req);
    assign off_s = alu_out[1:0];

    // Byte-enable / write-lane encoding and store alignment check; a read wins over a write.
    always_comb begin
        enc_mbe_s   = 4'b1111;
        enc_wdata_s = 32'd0;
        store_mis_s = 1'b0;
        if (mem_read_req || !mem_write_req) begin
            enc_mbe_s   = 4'b1111;
            enc_wdata_s = 32'd0;
            store_mis_s = 1'b0;
        end else begin
            case (funct3)
                3'b000: begin
                    enc_mbe_s   = 4'b0001 << off_s;
                    enc_wdata_s = {4{rs2_out[7:0]}};
                    store_mis_s = 1'b0;
                end
                3'b001: begin
                    enc_mbe_s   = off_s[1] ? 4'b1100 : 4'b0011;
                    enc_wdata_s = {2{rs2_out[15:0]}};
                    store_mis_s = off_s[0];
                end
                default: begin
                    enc_mbe_s   = 4'b1111;
                    enc_wdata_s = rs2_out;
                    store_mis_s = (off_s != 2'b00);
                end
            endcase
        end
    end

    // Next-state and request-register update for the IDLE/ACCESS/DONE handshake.
    always_comb begin
        state_d      = state_q;
        data_read_d  = data_read_q;
        data_write_d = data_write_q;
        data_addr_d  = data_addr_q;
        data_mbe_d   = data_mbe_q;
        data_wdata_d = data_wdata_q;
        load_data_d  = load_data_q;
        addr_low_d   = addr_low_q;
        stall_s      = 1'b0;
        mis_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (store_mis_s) begin
                        mis_s   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        data_read_d  = mem_read_req;
                        data_write_d = mem_write_req & ~mem_read_req;
                        data_addr_d  = {alu_out[31:2], 2'b00};
                        data_mbe_d   = enc_mbe_s;
                        data_wdata_d = enc_wdata_s;
                        addr_low_d   = off_s;
                        stall_s      = 1'b1;
                        state_d      = ACCESS;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                stall_s = 1'b1;
                if (data_resp) begin
                    data_read_d  = 1'b0;
                    data_write_d = 1'b0;
                    if (data_read_q) begin
                        load_data_d = data_rdata;
                    end else begin
                        load_data_d = load_data_q;
                    end
                    state_d = DONE;
                end else begin
                    state_d = ACCESS;
                end
            end
            DONE: begin
                // Stall released for one cycle so the instruction leaves MEM.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            data_read_q  <= 1'b0;
            data_write_q <= 1'b0;
            data_addr_q  <= 32'd0;
            data_mbe_q   <= 4'd0;
            data_wdata_q <= 32'd0;
            load_data_q  <= 32'd0;
            addr_low_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            data_read_q  <= data_read_d;
            data_write_q <= data_write_d;
            data_addr_q  <= data_addr_d;
            data_mbe_q   <= data_mbe_d;
            data_wdata_q <= data_wdata_d;
            load_data_q  <= load_data_d;
            addr_low_q   <= addr_low_d;
        end
    end

    assign data_read  = data_read_q;
    assign data_write = data_write_q;
    assign data_addr  = data_addr_q;
    assign data_mbe   = data_mbe_q;
    assign data_wdata = data_wdata_q;
    assign load_data  = load_data_q;
    assign addr_low   = addr_low_q;
    assign mem_stall  = stall_s & ~rst;
    assign misaligned = mis_s & ~rst;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed vector table, a reset
// mid-access sequence and randomized cycles, all against a transaction-level
// reference model.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst, mem_valid, mem_read_req, mem_write_req, data_resp;
    logic [2:0]  funct3;
    logic [31:0] alu_out, rs2_out, data_rdata;
    logic        data_read, data_write, mem_stall, misaligned;
    logic [31:0] data_addr, data_wdata, load_data;
    logic [3:0]  data_mbe;
    logic [1:0]  addr_low;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_access_unit dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_read_req(mem_read_req),
        .mem_write_req(mem_write_req), .funct3(funct3), .alu_out(alu_out),
        .rs2_out(rs2_out), .data_rdata(data_rdata), .data_resp(data_resp),
        .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
        .data_mbe(data_mbe), .data_wdata(data_wdata), .load_data(load_data),
        .addr_low(addr_low), .mem_stall(mem_stall), .misaligned(misaligned)
    );

    // Reference model: one outstanding transaction plus a one-cycle retire slot.
    logic        m_busy, m_retire, m_read, m_write;
    logic [31:0] m_addr, m_wdata, m_load;
    logic [3:0]  m_mbe;
    logic [1:0]  m_low;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        int          waits;
        logic [31:0] rdata;
        logic [3:0]  mbe;
        logic [31:0] wdata;
        logic        mis;
    } vec_t;

    vec_t vecs[11];

    function automatic logic ref_mis(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a);
        int off;
        off = int'(a % 32'd4);
        if (rd || !wr) return 1'b0;
        if (f3 == 3'd0) return 1'b0;
        if (f3 == 3'd1) return (off % 2) != 0;
        return off != 0;
    endfunction

    function automatic logic [3:0] ref_mbe(input logic rd, input logic [2:0] f3,
                                           input logic [31:0] a);
        int off;
        off = int'(a % 32'd4);
        if (rd) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << off);
        if (f3 == 3'd1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic rd, input logic [2:0] f3,
                                              input logic [31:0] d);
        if (rd) return 32'd0;
        if (f3 == 3'd0) return (d % 32'd256) * 32'h01010101;
        if (f3 == 3'd1) return (d % 32'h10000) * 32'h00010001;
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply inputs for one cycle and compare every output to the model at the falling edge.
    task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                         input logic resp, input logic r);
        logic idle, req, mis, stall;
        rst = r; mem_valid = v; mem_read_req = rd; mem_write_req = wr; funct3 = f3;
        alu_out = a; rs2_out = d; data_rdata = rdat; data_resp = resp;
        @(negedge clk);
        idle  = !m_busy && !m_retire;
        req   = v && (rd || wr);
        mis   = !r && idle && v && ref_mis(rd, wr, f3, a);
        stall = !r && (m_busy || (idle && req && !ref_mis(rd, wr, f3, a)));
        chk("data_read",  32'(data_read),  32'(m_read));
        chk("data_write", 32'(data_write), 32'(m_write));
        chk("data_addr",  data_addr,       m_addr);
        chk("data_mbe",   32'(data_mbe),   32'(m_mbe));
        chk("data_wdata", data_wdata,      m_wdata);
        chk("load_data",  load_data,       m_load);
        chk("addr_low",   32'(addr_low),   32'(m_low));
        chk("mem_stall",  32'(mem_stall),  32'(stall));
        chk("misaligned", 32'(misaligned), 32'(mis));
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_retire = 1'b0; m_read = 1'b0; m_write = 1'b0;
        m_addr = 32'd0; m_wdata = 32'd0; m_load = 32'd0; m_mbe = 4'd0; m_low = 2'd0;
    endtask

    // Clock edge: advance the model with the inputs currently applied.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_retire) begin
            m_retire = 1'b0;
        end else if (m_busy) begin
            if (data_resp) begin
                if (m_read) m_load = data_rdata;
                m_read = 1'b0; m_write = 1'b0; m_busy = 1'b0; m_retire = 1'b1;
            end
        end else if (mem_valid && (mem_read_req || mem_write_req) &&
                     !ref_mis(mem_read_req, mem_write_req, funct3, alu_out)) begin
            m_busy  = 1'b1;
            m_read  = mem_read_req;
            m_write = mem_write_req && !mem_read_req;
            m_addr  = alu_out - (alu_out % 32'd4);
            m_mbe   = ref_mbe(mem_read_req, funct3, alu_out);
            m_wdata = ref_wdata(mem_read_req, funct3, rs2_out);
            m_low   = 2'(alu_out % 32'd4);
        end
        #1;
    endtask

    // One directed transaction from the table, with explicit expectations.
    task automatic run_vec(input vec_t t);
        int rd_cycles;
        rd_cycles = 0;
        drive(1'b1, t.rd, t.wr, t.f3, t.addr, t.rs2, 32'd0, 1'b0, 1'b0);
        chk("vec_misaligned", 32'(misaligned), 32'(t.mis));
        chk("vec_stall_c0",   32'(mem_stall),  32'(!t.mis));
        tick();
        if (t.mis) begin
            drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            chk("vec_mis_no_write", 32'(data_write), 32'd0);
            chk("vec_mis_no_read",  32'(data_read),  32'd0);
            tick();
        end else begin
            for (int k = 0; k <= t.waits; k++) begin
                drive(1'b1, t.rd, t.wr, t.f3, t.addr, t.rs2, t.rdata, k == t.waits, 1'b0);
                chk("vec_addr",  data_addr, {t.addr[31:2], 2'b00});
                chk("vec_mbe",   32'(data_mbe), 32'(t.mbe));
                chk("vec_wdata", data_wdata, t.wdata);
                chk("vec_write", 32'(data_write), 32'(t.wr && !t.rd));
                chk("vec_stall_access", 32'(mem_stall), 32'd1);
                if (data_read) rd_cycles++;
                tick();
            end
            drive(1'b1, t.rd, t.wr, t.f3, t.addr, t.rs2, 32'd0, 1'b0, 1'b0);
            chk("vec_stall_done", 32'(mem_stall), 32'd0);
            chk("vec_req_cleared", 32'(data_read | data_write), 32'd0);
            chk("vec_addr_low", 32'(addr_low), 32'(t.addr[1:0]));
            chk("vec_read_cycles", 32'(rd_cycles), t.rd ? 32'(t.waits + 1) : 32'd0);
            if (t.rd) chk("vec_load_data", load_data, t.rdata);
            tick();
            drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        //         rd    wr    f3    addr          rs2           waits rdata         mbe   wdata         mis
        vecs[0]  = '{1'b0, 1'b1, 3'd2, 32'h00000100, 32'hDEADBEEF, 0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'd0, 32'h00000203, 32'h000000A5, 1, 32'h0,        4'h8, 32'hA5A5A5A5, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'd1, 32'h00000202, 32'h00001234, 0, 32'h0,        4'hC, 32'h12341234, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'd2, 32'h00000306, 32'h0,        4, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'd1, 32'h00000101, 32'h0000FFFF, 0, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 1'b1, 3'd2, 32'h00000102, 32'h11111111, 0, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 1'b1, 3'd0, 32'h00000401, 32'h000000FF, 1, 32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'd0, 32'h00000500, 32'h1234567E, 2, 32'h0,        4'h1, 32'h7E7E7E7E, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'd1, 32'h00000600, 32'h9999ABCD, 0, 32'h0,        4'h3, 32'hABCDABCD, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'd7, 32'h00000700, 32'h01020304, 0, 32'h0,        4'hF, 32'h01020304, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'd2, 32'h00000703, 32'h0,        0, 32'h5A5A0F0F, 4'hF, 32'h0,        1'b0};

        rst = 1'b1; mem_valid = 1'b0; mem_read_req = 1'b0; mem_write_req = 1'b0;
        funct3 = 3'd0; alu_out = 32'd0; rs2_out = 32'd0; data_rdata = 32'd0; data_resp = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state, with a request presented while reset is held.
        drive(1'b1, 1'b0, 1'b1, 3'd2, 32'h00000104, 32'h1, 32'd0, 1'b1, 1'b1);
        chk("reset_stall", 32'(mem_stall), 32'd0);
        chk("reset_read",  32'(data_read), 32'd0);
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during ACCESS, then a stray response.
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h00000800, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h00000800, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("rst_mid_read_before", 32'(data_read), 32'd1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h00000800, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("rst_mid_stall", 32'(mem_stall), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h55AA55AA, 1'b1, 1'b0);
        chk("rst_mid_read_after", 32'(data_read), 32'd0);
        chk("rst_mid_addr", data_addr, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("rst_mid_load_data", load_data, 32'd0);
        chk("rst_mid_stall_after", 32'(mem_stall), 32'd0);
        tick();

        // Randomized cycles against the model.
        for (int c = 0; c < 600; c++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            int sel;
            sel = int'($urandom_range(0, 3));
            f3 = (sel == 3) ? 3'($urandom_range(0, 7)) : 3'(sel);
            a = $urandom;
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  f3, a, $urandom, $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 39) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
